// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the 1-to-2 stream dispatcher.
package demux_dispatch_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int CH0 = 0;
  localparam int CH1 = 1;

endpackage

// File: rtl/dispatch_slot.sv
// Single-entry valid/ready holding register with a saturating count of drained words.
module dispatch_slot #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready_in,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free,
  output logic [CNT_W-1:0]  cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    drain   = valid_q && ready_in;
    // A word leaving this cycle frees the slot, so a new word can land on the same edge.
    free    = !valid_q || ready_in;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (drain) begin
      valid_d = 1'b0;
      cnt_d   = sat_inc(cnt_q);
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/demux_dispatch.sv
// Registered 1-to-2 dispatcher: routes each accepted word to one channel by in_sel or round-robin.
module demux_dispatch
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              mode,
  output logic [1:0]        out_valid,
  input  logic [1:0]        out_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              rr_ptr
);

  logic       rr_ptr_q, rr_ptr_d;
  logic       dest;
  logic       accept;
  logic [1:0] free;
  logic [1:0] load;

  always_comb begin
    dest     = (mode_e'(mode) == MODE_RR) ? rr_ptr_q : in_sel;
    // Only the chosen channel gates input; RR never skips ahead to an idle channel.
    in_ready = dest ? free[CH1] : free[CH0];
    accept   = in_valid && in_ready;
    load     = 2'b00;
    load[dest] = accept;
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode_e'(mode) == MODE_RR)) rr_ptr_d = ~rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

  dispatch_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load[CH0]),
    .load_data (in_data),
    .ready_in  (out_ready[CH0]),
    .valid     (out_valid[CH0]),
    .data      (out0_data),
    .free      (free[CH0]),
    .cnt       (cnt0)
  );

  dispatch_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load[CH1]),
    .load_data (in_data),
    .ready_in  (out_ready[CH1]),
    .valid     (out_valid[CH1]),
    .data      (out1_data),
    .free      (free[CH1]),
    .cnt       (cnt1)
  );

endmodule

// File: tb/tb_demux_dispatch.sv
// Bench for demux_dispatch: directed vector table, random traffic against a queue model, saturation/reset sequences.
module tb_demux_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] out_ready = 2'b11;

  logic       in_ready, rr_ptr;
  logic [1:0] out_valid;
  logic [7:0] out0_data, out1_data, cnt0, cnt1;

  logic       s_in_ready, s_rr_ptr;
  logic [1:0] s_out_valid;
  logic [7:0] s_out0_data, s_out1_data;
  logic [2:0] s_cnt0, s_cnt1;

  always #5 clk = ~clk;

  demux_dispatch #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out0_data(out0_data), .out1_data(out1_data), .cnt0(cnt0), .cnt1(cnt1), .rr_ptr(rr_ptr)
  );

  demux_dispatch #(.DATA_W(8), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_sel(in_sel), .mode(mode), .out_valid(s_out_valid), .out_ready(out_ready),
    .out0_data(s_out0_data), .out1_data(s_out1_data), .cnt0(s_cnt0), .cnt1(s_cnt1), .rr_ptr(s_rr_ptr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a FIFO of words in flight, counters are plain integers.
  logic [7:0] m_q0[$];
  logic [7:0] m_q1[$];
  logic [7:0] m_last [2];
  int         m_cnt [2];
  logic       m_rr;
  bit         mchk = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    logic       d;
    logic       ir;
    logic [1:0] ov;
    @(negedge clk);
    d  = mode ? m_rr : in_sel;
    ir = (d ? (m_q1.size() == 0) : (m_q0.size() == 0)) || out_ready[d];
    ov = {m_q1.size() != 0, m_q0.size() != 0};
    if (mchk) begin
      chk("m_in_ready", in_ready, ir);
      chk("m_out_valid", out_valid, ov);
      chk("m_out0_data", out0_data, m_last[0]);
      chk("m_out1_data", out1_data, m_last[1]);
      chk("m_cnt0", cnt0, sat(m_cnt[0], 255));
      chk("m_cnt1", cnt1, sat(m_cnt[1], 255));
      chk("m_rr_ptr", rr_ptr, m_rr);
      chk("s_in_ready", s_in_ready, ir);
      chk("s_out_valid", s_out_valid, ov);
      chk("s_out0_data", s_out0_data, m_last[0]);
      chk("s_cnt0", s_cnt0, sat(m_cnt[0], 7));
      chk("s_cnt1", s_cnt1, sat(m_cnt[1], 7));
    end
    if (rst) begin
      m_q0.delete(); m_q1.delete();
      m_last[0] = 0; m_last[1] = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_rr = 0;
    end else begin
      if (m_q0.size() != 0 && out_ready[0]) begin void'(m_q0.pop_front()); m_cnt[0]++; end
      if (m_q1.size() != 0 && out_ready[1]) begin void'(m_q1.pop_front()); m_cnt[1]++; end
      if (in_valid && ir) begin
        if (d) m_q1.push_back(in_data); else m_q0.push_back(in_data);
        m_last[d] = in_data;
        if (mode) m_rr = ~m_rr;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst, iv;
    logic [7:0] d;
    logic       sel, mode;
    logic [1:0] ordy;
    logic       chk_ir, ir;
    logic [1:0] ov;
    logic [7:0] d0, d1, c0, c1;
    logic       rr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic sel,
                     input logic md, input logic [1:0] ordy, input logic ci, input logic ir,
                     input logic [1:0] ov, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] c0, input logic [7:0] c1, input logic rr);
    vec_t v;
    v = '{r, iv, d, sel, md, ordy, ci, ir, ov, d0, d1, c0, c1, rr};
    tbl.push_back(v);
  endtask

  initial begin
    // rst iv data sel mode ordy chk_ir ir | ov d0 d1 c0 c1 rr (after the edge)
    add(1, 1, 8'hEE, 0, 0, 2'b11, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 0);
    add(1, 1, 8'hEE, 1, 0, 2'b11, 0, 0, 2'b00, 8'h00, 8'h00, 0, 0, 0);
    add(0, 1, 8'hA1, 0, 0, 2'b11, 1, 1, 2'b01, 8'hA1, 8'h00, 0, 0, 0);
    add(0, 1, 8'hB2, 1, 0, 2'b11, 1, 1, 2'b10, 8'hA1, 8'hB2, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 2'b11, 1, 1, 2'b00, 8'hA1, 8'hB2, 1, 1, 0);
    add(0, 1, 8'h10, 1, 1, 2'b11, 1, 1, 2'b01, 8'h10, 8'hB2, 1, 1, 1);
    add(0, 1, 8'h11, 0, 1, 2'b11, 1, 1, 2'b10, 8'h10, 8'h11, 2, 1, 0);
    add(0, 1, 8'h12, 1, 1, 2'b11, 1, 1, 2'b01, 8'h12, 8'h11, 2, 2, 1);
    add(0, 1, 8'h13, 0, 1, 2'b11, 1, 1, 2'b10, 8'h12, 8'h13, 3, 2, 0);
    add(0, 0, 8'h00, 0, 1, 2'b11, 1, 1, 2'b00, 8'h12, 8'h13, 3, 3, 0);
    add(0, 1, 8'h55, 0, 0, 2'b10, 1, 1, 2'b01, 8'h55, 8'h13, 3, 3, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 8'h66, 0, 0, 2'b10, 1, 0, 2'b01, 8'h55, 8'h13, 3, 3, 0);
    add(0, 1, 8'h66, 0, 0, 2'b11, 1, 1, 2'b01, 8'h66, 8'h13, 4, 3, 0);
    add(0, 0, 8'h00, 0, 0, 2'b11, 1, 1, 2'b00, 8'h66, 8'h13, 5, 3, 0);
    add(0, 1, 8'h20, 0, 1, 2'b01, 1, 1, 2'b01, 8'h20, 8'h13, 5, 3, 1);
    add(0, 1, 8'h21, 0, 1, 2'b01, 1, 1, 2'b10, 8'h20, 8'h21, 6, 3, 0);
    add(0, 1, 8'h22, 0, 1, 2'b01, 1, 1, 2'b11, 8'h22, 8'h21, 6, 3, 1);
    add(0, 1, 8'h23, 0, 1, 2'b01, 1, 0, 2'b10, 8'h22, 8'h21, 7, 3, 1);
    add(0, 1, 8'h23, 0, 1, 2'b01, 1, 0, 2'b10, 8'h22, 8'h21, 7, 3, 1);
    add(0, 1, 8'h23, 0, 1, 2'b11, 1, 1, 2'b10, 8'h22, 8'h23, 7, 4, 0);
    add(0, 1, 8'h24, 1, 1, 2'b11, 1, 1, 2'b01, 8'h24, 8'h23, 7, 5, 1);
    add(0, 0, 8'h00, 0, 1, 2'b11, 1, 1, 2'b00, 8'h24, 8'h23, 8, 5, 1);
    add(0, 1, 8'h30, 1, 0, 2'b11, 1, 1, 2'b10, 8'h24, 8'h30, 8, 5, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d;
      in_sel = tbl[i].sel; mode = tbl[i].mode; out_ready = tbl[i].ordy;
      #1;
      if (tbl[i].chk_ir) chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].ir);
      step();
      mchk = 1;
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("v%0d_out0_data", i), out0_data, tbl[i].d0);
      chk($sformatf("v%0d_out1_data", i), out1_data, tbl[i].d1);
      chk($sformatf("v%0d_cnt0", i), cnt0, tbl[i].c0);
      chk($sformatf("v%0d_cnt1", i), cnt1, tbl[i].c1);
      chk($sformatf("v%0d_rr_ptr", i), rr_ptr, tbl[i].rr);
    end

    // Random traffic with occasional resets and mode flips.
    for (int k = 0; k < 800; k++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_sel    = 1'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      out_ready = 2'($urandom);
      step();
    end

    // Counter saturation: ten words to channel 0.
    rst = 1; in_valid = 0; out_ready = 2'b11; mode = 0; in_sel = 0;
    step();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = 8'(8'h40 + i);
      step();
    end
    in_valid = 0;
    step(); step(); step();
    chk("sat_cnt0_w3", s_cnt0, 7);
    chk("sat_cnt0_w8", cnt0, 10);
    chk("sat_cnt1_w3", s_cnt1, 0);

    // Reset while both channels hold words.
    out_ready = 2'b00; in_valid = 1; in_sel = 0; in_data = 8'h77;
    step();
    in_sel = 1; in_data = 8'h88;
    step();
    chk("full_out_valid", out_valid, 2'b11);
    rst = 1;
    step();
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_rr_ptr", rr_ptr, 0);
    rst = 0; in_valid = 0; out_ready = 2'b11;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/demux_dispatch.md
Name: demux_dispatch

Overview:
- Registered 1-to-2 stream dispatcher with valid/ready handshakes on the input and on both outputs.
- Each accepted input word goes to one output channel. In SEL mode the channel is chosen by in_sel. In RR mode channels alternate.
- Sits directly upstream of the combinational 1:2 demux datapath and replaces its free-running sel/in drive with backpressure-aware, one-word-per-channel buffering plus per-channel delivery counters.

Parameters:
- DATA_W, 8: width of data word.
- CNT_W, 8: width of each per-channel delivered-word counter (saturating).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: input word present.
- in_ready, output, 1: dispatcher accepts word this cycle.
- in_data, input, DATA_W: input word.
- in_sel, input, 1: destination channel in SEL mode (0 -> ch0, 1 -> ch1). Ignored in RR mode.
- mode, input, 1: 0 = SEL, 1 = RR.
- out_valid, output, 2: bit i = channel i holds a word.
- out_ready, input, 2: bit i = channel i consumer takes the word.
- out0_data, output, DATA_W: channel 0 word.
- out1_data, output, DATA_W: channel 1 word.
- cnt0, output, CNT_W: words delivered on channel 0.
- cnt1, output, CNT_W: words delivered on channel 1.
- rr_ptr, output, 1: next RR destination (status only).

Behaviour:
- Reset state (rst high at a clock edge):
  - out_valid = 2'b00; out0_data = out1_data = 0.
  - cnt0 = cnt1 = 0; rr_ptr = 0.
  - rst overrides all other activity in that cycle, including mid-transfer. Words held in channel registers are discarded and not counted.
- Destination:
  - dest = mode ? rr_ptr : in_sel.
  - Evaluated combinationally in the same cycle as the handshake.
- Channel register i per cycle:
  - free_i = !out_valid[i] || out_ready[i]. A held word draining this cycle frees the slot, so full throughput is 1 word/cycle per channel.
  - in_ready = free_dest. in_ready must not depend on in_valid.
  - Accept = in_valid && in_ready. On accept: load channel dest data and set out_valid[dest] = 1 at the next edge.
  - Drain_i = out_valid[i] && out_ready[i]. With drain and no accept to i: out_valid[i] = 0 next cycle. Data register holds its value.
  - Drain and accept to the same channel in the same cycle: out_valid[i] stays 1, data is replaced by the new word.
  - Latency: input word visible on its output exactly 1 cycle after acceptance.
  - A held word and its data stay stable while out_valid[i] && !out_ready[i].
- Round-robin:
  - rr_ptr toggles only on an accept while mode = 1.
  - A stalled destination blocks input. RR never skips a busy channel, so order is strict alternation.
  - Switching mode does not reset rr_ptr. rr_ptr keeps its value while in SEL mode.
- Counters:
  - cnt_i increments by 1 on each drain_i.
  - Saturates at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - Drains on both channels plus an accept all complete in one cycle.
  - Stalled non-destination channel: no effect on in_ready.
- Data invariants (assertions in bench):
  - No word is lost or duplicated.
  - Per-channel order is preserved.
  - out_valid[i] never drops without drain_i or rst.
  - in_sel is don't-care in RR mode.

Decomposition:
- Package demux_dispatch_pkg holds:
  - typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mode_e;
  - channel index constants CH0 = 0, CH1 = 1.
- One natural sub-module, dispatch_slot: a single-entry valid/ready register with a saturating drain counter.
  - Ports: clk, rst, load, load_data, ready_in, valid, data, free, cnt.
  - Instantiated twice. The top level holds dest/rr_ptr logic and in_ready.

Test Plan:
- Reset check: hold rst 2 cycles with in_valid = 1 -> out_valid = 00, cnt0 = cnt1 = 0, rr_ptr = 0. No accept during rst.
- SEL mode with both out_ready = 1: send 0xA1 with sel = 0, then 0xB2 with sel = 1 on back-to-back cycles.
  - Cycle+1: out0_data = 0xA1, out_valid = 01.
  - Cycle+2: out1_data = 0xB2, out_valid = 10.
  - Result: cnt0 = 1, cnt1 = 1.
- RR mode, 4 words 0x10..0x13, continuous ready -> 0x10, 0x12 on ch0; 0x11, 0x13 on ch1; rr_ptr ends at 0; cnt0 = cnt1 = 2.
- Backpressure, SEL sel = 0, out_ready[0] = 0:
  - Word 0x55 is accepted; second word 0x66 sees in_ready = 0 and out0_data holds 0x55 for 5 cycles.
  - Raise out_ready[0]: 0x55 drains and 0x66 is accepted the same cycle; 0x66 appears next cycle. Channel 1 is unaffected.
- RR stall: out_ready[1] = 0 with ch1 full and rr_ptr = 1 -> in_ready = 0 even though ch0 is empty; no skip. Releasing ready resumes alternation.
- Saturation and mid-operation reset:
  - CNT_W = 3: push 10 words to ch0 -> cnt0 = 7 and holds.
  - Then assert rst while out_valid = 11 -> next cycle all outputs return to reset values.
